hms_time_counter: RTL and testbench

//   BCD hours:minutes:seconds time-of-day counter for the digital clock datapath.

---
 rtl/hms_time_counter.sv | 218 +++++++++++++++++++++
 tb/tb_hms_time_counter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hms_time_counter.sv
// BCD hh:mm:ss time-of-day counter with 24h or 12h (AM/PM) hour modes, field adjust and day-wrap pulse.
// Optional alarm compare is built when the macro HMS_ALARM_EN is defined.
module hms_time_counter #(
    parameter int HOUR_MODE = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       run,
    input  logic [1:0] inc_sel,
    input  logic       inc,
    output logic [1:0] h1,
    output logic [3:0] h2,
    output logic [2:0] m1,
    output logic [3:0] m2,
    output logic [2:0] s1,
    output logic [3:0] s2,
    output logic       pm,
    output logic       day_wrap,
    input  logic       alarm_arm,
    input  logic       alarm_cap,
    output logic       alarm
);

    localparam bit         MODE12 = (HOUR_MODE == 12);
    localparam logic [1:0] RST_H1 = MODE12 ? 2'd1 : 2'd0;
    localparam logic [3:0] RST_H2 = MODE12 ? 4'd2 : 4'd0;

    typedef struct packed {
        logic [1:0] tens;
        logic [3:0] units;
        logic       roll;
    } hour_t;

    typedef struct packed {
        logic [2:0] tens;
        logic [3:0] units;
        logic       carry;
    } min_t;

    // roll marks 23->00 in 24h mode and 11->12 (AM/PM flip) in 12h mode
    function automatic hour_t next_hour(input logic [1:0] th, input logic [3:0] uh);
        hour_t r;
        r.tens  = th;
        r.units = uh;
        r.roll  = 1'b0;
        if (MODE12) begin
            if (th == 2'd1 && uh == 4'd2) begin
                r.tens  = 2'd0;
                r.units = 4'd1;
            end else if (th == 2'd1 && uh == 4'd1) begin
                r.units = 4'd2;
                r.roll  = 1'b1;
            end else if (uh == 4'd9) begin
                r.tens  = 2'd1;
                r.units = 4'd0;
            end else begin
                r.units = uh + 4'd1;
            end
        end else begin
            if (th == 2'd2 && uh == 4'd3) begin
                r.tens  = 2'd0;
                r.units = 4'd0;
                r.roll  = 1'b1;
            end else if (uh == 4'd9) begin
                r.tens  = th + 2'd1;
                r.units = 4'd0;
            end else begin
                r.units = uh + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic min_t next_min(input logic [2:0] tm, input logic [3:0] um);
        min_t r;
        r.tens  = tm;
        r.units = um + 4'd1;
        r.carry = 1'b0;
        if (um == 4'd9) begin
            r.units = 4'd0;
            if (tm == 3'd5) begin
                r.tens  = 3'd0;
                r.carry = 1'b1;
            end else begin
                r.tens = tm + 3'd1;
            end
        end
        return r;
    endfunction

    logic       adj_min, adj_hr, adv;
    hour_t      hr_nxt;
    min_t       mn_nxt;
    logic [1:0] h1_n;
    logic [3:0] h2_n;
    logic [2:0] m1_n;
    logic [3:0] m2_n;
    logic [2:0] s1_n;
    logic [3:0] s2_n;
    logic       pm_n, wrap_n;

    assign adj_min = inc && (inc_sel == 2'b01);
    assign adj_hr  = inc && (inc_sel == 2'b10);
    assign adv     = tick && run && !adj_min && !adj_hr;
    assign hr_nxt  = next_hour(h1, h2);
    assign mn_nxt  = next_min(m1, m2);

    always_comb begin
        h1_n   = h1;
        h2_n   = h2;
        m1_n   = m1;
        m2_n   = m2;
        s1_n   = s1;
        s2_n   = s2;
        pm_n   = pm;
        wrap_n = 1'b0;
        if (adj_min || adj_hr) begin
            s1_n = 3'd0;
            s2_n = 4'd0;
            if (adj_min) begin
                m1_n = mn_nxt.tens;
                m2_n = mn_nxt.units;
            end else begin
                h1_n = hr_nxt.tens;
                h2_n = hr_nxt.units;
                if (MODE12 && hr_nxt.roll) pm_n = ~pm;
            end
        end else if (adv) begin
            if (s2 != 4'd9) begin
                s2_n = s2 + 4'd1;
            end else begin
                s2_n = 4'd0;
                if (s1 != 3'd5) begin
                    s1_n = s1 + 3'd1;
                end else begin
                    s1_n = 3'd0;
                    m1_n = mn_nxt.tens;
                    m2_n = mn_nxt.units;
                    if (mn_nxt.carry) begin
                        h1_n = hr_nxt.tens;
                        h2_n = hr_nxt.units;
                        // in 12h mode the day ends only on the PM->AM flip
                        if (hr_nxt.roll) begin
                            if (MODE12) begin
                                pm_n   = ~pm;
                                wrap_n = pm;
                            end else begin
                                wrap_n = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h1       <= RST_H1;
            h2       <= RST_H2;
            m1       <= 3'd0;
            m2       <= 4'd0;
            s1       <= 3'd0;
            s2       <= 4'd0;
            pm       <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            h1       <= h1_n;
            h2       <= h2_n;
            m1       <= m1_n;
            m2       <= m2_n;
            s1       <= s1_n;
            s2       <= s2_n;
            pm       <= pm_n;
            day_wrap <= wrap_n;
        end
    end

`ifdef HMS_ALARM_EN
    logic [1:0] al_h1;
    logic [3:0] al_h2;
    logic [2:0] al_m1;
    logic [3:0] al_m2;
    logic       al_pm;
    logic       hit;

    // only a tick rolling into second 00 can fire; adjusts are excluded via adv
    assign hit = adv && alarm_arm && (s1_n == 3'd0) && (s2_n == 4'd0) &&
                 (h1_n == al_h1) && (h2_n == al_h2) && (m1_n == al_m1) &&
                 (m2_n == al_m2) && (pm_n == al_pm);

    always_ff @(posedge clk) begin
        if (reset) begin
            al_h1 <= RST_H1;
            al_h2 <= RST_H2;
            al_m1 <= 3'd0;
            al_m2 <= 4'd0;
            al_pm <= 1'b0;
            alarm <= 1'b0;
        end else begin
            if (alarm_cap) begin
                al_h1 <= h1;
                al_h2 <= h2;
                al_m1 <= m1;
                al_m2 <= m2;
                al_pm <= pm;
            end
            alarm <= hit;
        end
    end
`else
    logic unused_alarm_in;
    assign unused_alarm_in = alarm_arm ^ alarm_cap;
    assign alarm           = 1'b0;
`endif

endmodule

// File: tb/tb_hms_time_counter.sv
// Scoreboard bench for hms_time_counter: a 24h and a 12h instance share stimulus and are checked
// every cycle against a seconds-of-day reference model.
module tb_hms_time_counter;

    logic       clk = 1'b0;
    logic       reset, tick, run, inc, alarm_arm, alarm_cap;
    logic [1:0] inc_sel;

    logic [1:0] a_h1, b_h1;
    logic [3:0] a_h2, b_h2, a_m2, b_m2, a_s2, b_s2;
    logic [2:0] a_m1, b_m1, a_s1, b_s1;
    logic       a_pm, b_pm, a_dw, b_dw, a_al, b_al;
    logic [22:0] obs24, obs12;

    always #5 clk = ~clk;

    hms_time_counter #(.HOUR_MODE(24)) u24 (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .inc_sel(inc_sel), .inc(inc),
        .h1(a_h1), .h2(a_h2), .m1(a_m1), .m2(a_m2), .s1(a_s1), .s2(a_s2),
        .pm(a_pm), .day_wrap(a_dw), .alarm_arm(alarm_arm), .alarm_cap(alarm_cap), .alarm(a_al)
    );

    hms_time_counter #(.HOUR_MODE(12)) u12 (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .inc_sel(inc_sel), .inc(inc),
        .h1(b_h1), .h2(b_h2), .m1(b_m1), .m2(b_m2), .s1(b_s1), .s2(b_s2),
        .pm(b_pm), .day_wrap(b_dw), .alarm_arm(alarm_arm), .alarm_cap(alarm_cap), .alarm(b_al)
    );

    assign obs24 = {a_h1, a_h2, a_m1, a_m2, a_s1, a_s2, a_pm, a_dw, a_al};
    assign obs12 = {b_h1, b_h2, b_m1, b_m2, b_s1, b_s2, b_pm, b_dw, b_al};

`ifdef HMS_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    typedef struct {
        logic [22:0] v24;
        logic [22:0] v12;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   passed = 0;

    // reference state: seconds since midnight, alarm hh/mm in 24h terms
    int m_t, m_alh, m_alm;
    bit m_dw, m_al;

    function automatic logic [22:0] pack(input bit m12, input int t, input bit dw, input bit al);
        int h, m, s, hd;
        bit p;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        if (m12) begin
            p  = (h >= 12);
            hd = h % 12;
            if (hd == 0) hd = 12;
        end else begin
            p  = 1'b0;
            hd = h;
        end
        return {2'(hd / 10), 4'(hd % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), p, dw, al};
    endfunction

    function automatic string show(input logic [22:0] v);
        return $sformatf("%0d%0d:%0d%0d:%0d%0d pm=%0d wrap=%0d alarm=%0d",
                         v[22:21], v[20:17], v[16:14], v[13:10], v[9:7], v[6:3], v[2], v[1], v[0]);
    endfunction

    task automatic cyc(input logic rst_i, input logic tck_i, input logic run_i, input logic inc_i,
                       input logic [1:0] sel_i, input logic cap_i, input logic arm_i);
        exp_t x;
        int   h, m;
        @(negedge clk);
        reset     = rst_i;
        tick      = tck_i;
        run       = run_i;
        inc       = inc_i;
        inc_sel   = sel_i;
        alarm_cap = cap_i;
        alarm_arm = arm_i;
        m_dw = 1'b0;
        m_al = 1'b0;
        if (rst_i) begin
            m_t   = 0;
            m_alh = 0;
            m_alm = 0;
        end else begin
            if (cap_i) begin
                m_alh = m_t / 3600;
                m_alm = (m_t / 60) % 60;
            end
            if (inc_i && (sel_i == 2'b01 || sel_i == 2'b10)) begin
                h = m_t / 3600;
                m = (m_t / 60) % 60;
                if (sel_i == 2'b01) m = (m + 1) % 60;
                else                h = (h + 1) % 24;
                m_t = h * 3600 + m * 60;
            end else if (tck_i && run_i) begin
                if (m_t == 86399) begin
                    m_t  = 0;
                    m_dw = 1'b1;
                end else begin
                    m_t = m_t + 1;
                end
                if ((m_t % 60) == 0 && arm_i && (m_t / 3600) == m_alh && ((m_t / 60) % 60) == m_alm)
                    m_al = ALARM_ON;
            end
        end
        x.v24 = pack(1'b0, m_t, m_dw, m_al);
        x.v12 = pack(1'b1, m_t, m_dw, m_al);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 2'b00, 0, 0);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL reset: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
        cyc(1, 1, 1, 1, 2'b10, 1, 1);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL reset_priority: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
    endtask

    task automatic goto_hm(input int h, input int m, input logic arm_i);
        cyc(1, 0, 0, 0, 2'b00, 0, arm_i);
        e = sb.pop_front();
        for (int i = 0; i < h + m; i++) begin
            cyc(0, 0, 1, 1, (i < h) ? 2'b10 : 2'b01, 0, arm_i);
            e = sb.pop_front();
            checks++;
            if ({obs24, obs12} !== {e.v24, e.v12})
                $display("FAIL set_time: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
            else passed++;
        end
    endtask

    task automatic run_ticks(input int n, input logic arm_i);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 1, 0, 2'b00, 0, arm_i);
            e = sb.pop_front();
            checks++;
            if ({obs24, obs12} !== {e.v24, e.v12})
                $display("FAIL tick: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
            else passed++;
        end
    endtask

    task automatic test_day_wrap();
        goto_hm(23, 59, 0);
        run_ticks(59, 0);
        cyc(0, 1, 1, 0, 2'b00, 0, 0);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL day_wrap: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
        cyc(0, 0, 1, 0, 2'b00, 0, 0);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL day_wrap_pulse: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
    endtask

    task automatic test_12h_rollover();
        goto_hm(11, 59, 0);
        run_ticks(59, 0);
        cyc(0, 1, 1, 0, 2'b00, 0, 0);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL noon: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
        for (int i = 0; i < 59; i++) begin
            cyc(0, 0, 1, 1, 2'b01, 0, 0);
            e = sb.pop_front();
        end
        run_ticks(59, 0);
        cyc(0, 1, 1, 0, 2'b00, 0, 0);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL one_pm: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
    endtask

    task automatic test_adjust();
        goto_hm(10, 15, 0);
        run_ticks(30, 0);
        cyc(0, 1, 1, 1, 2'b01, 0, 0);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL adjust_over_tick: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
        for (int i = 0; i < 43; i++) begin
            cyc(0, 0, 1, 1, 2'b01, 0, 0);
            e = sb.pop_front();
        end
        run_ticks(5, 0);
        cyc(0, 0, 1, 1, 2'b01, 0, 0);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL minute_wrap: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 1, 1, (i == 0) ? 2'b00 : 2'b11, 0, 0);
            e = sb.pop_front();
            checks++;
            if ({obs24, obs12} !== {e.v24, e.v12})
                $display("FAIL idle_sel_tick: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
            else passed++;
        end
        for (int i = 0; i < 14; i++) begin
            cyc(0, 0, 1, 1, 2'b10, 0, 0);
            e = sb.pop_front();
            checks++;
            if ({obs24, obs12} !== {e.v24, e.v12})
                $display("FAIL hour_adjust: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
            else passed++;
        end
    endtask

    task automatic test_freeze_and_reset();
        goto_hm(5, 42, 0);
        run_ticks(17, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0, 0, 2'b00, 0, 0);
            e = sb.pop_front();
            checks++;
            if ({obs24, obs12} !== {e.v24, e.v12})
                $display("FAIL frozen: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
            else passed++;
        end
        cyc(1, 1, 1, 0, 2'b00, 0, 0);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL reset_mid_count: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
        cyc(0, 1, 0, 1, 2'b10, 0, 0);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL adjust_frozen: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
    endtask

    task automatic test_alarm();
        goto_hm(7, 30, 1);
        cyc(0, 0, 1, 0, 2'b00, 1, 1);
        e = sb.pop_front();
        for (int i = 0; i < 59; i++) begin
            cyc(0, 0, 1, 1, 2'b01, 0, 1);
            e = sb.pop_front();
        end
        run_ticks(59, 1);
        cyc(0, 1, 1, 0, 2'b00, 0, 1);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL alarm_fire: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
        cyc(0, 0, 1, 0, 2'b00, 0, 1);
        e = sb.pop_front();
        checks++;
        if ({obs24, obs12} !== {e.v24, e.v12})
            $display("FAIL alarm_pulse: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
        else passed++;
        for (int i = 0; i < 59; i++) begin
            cyc(0, 0, 1, 1, 2'b01, 0, 0);
            e = sb.pop_front();
        end
        run_ticks(60, 0);
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 1, 1, 2'b01, 0, 1);
            e = sb.pop_front();
            checks++;
            if ({obs24, obs12} !== {e.v24, e.v12})
                $display("FAIL alarm_on_adjust: got %s | %s want %s | %s", show(obs24), show(obs12), show(e.v24), show(e.v12));
            else passed++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        tick      = 1'b0;
        run       = 1'b0;
        inc       = 1'b0;
        inc_sel   = 2'b00;
        alarm_cap = 1'b0;
        alarm_arm = 1'b0;
        m_t   = 0;
        m_alh = 0;
        m_alm = 0;
        m_dw  = 1'b0;
        m_al  = 1'b0;
        test_reset();
        test_day_wrap();
        test_12h_rollover();
        test_adjust();
        test_freeze_and_reset();
        test_alarm();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
